dmem_responder: RTL and testbench

Data-memory responder at the far end of the CPU core's data port. It accepts the core's combinational EX-stage requests (address, write data, write/read enables, funct3-style size) and returns load data aligned and extended one cycle later, in time for the MEM stage. It owns a word-organised SRAM array with byte-lane writes. When configured with wait states, it drives the core-wide hold input to freeze the pipeline for the access.

---
 rtl/dmem_responder.sv | 143 ++++++++++++++
 tb/tb_dmem_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised byte-lane SRAM with aligned/extended loads,
// fault detection and optional wait-state hold towards the core.
`default_nettype none

module dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          DEPTH       = 4096,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  input  logic        re_i,
  input  logic [2:0]  size_i,
  output logic [31:0] rdata_o,
  output logic        hold_o,
  output logic        err_o
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(4 * DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        hold, do_access;
  logic        req, in_range, bad_size, is_half, is_word, fault;
  logic [32:0] off;
  logic [AW-1:0] idx;
  logic [31:0] rword, lane, load_val, wlane;
  logic [15:0] half;
  logic [3:0]  be;

  logic [31:0] mem [DEPTH];

  assign req = we_i | re_i;

  // 33-bit subtraction: bit 32 set means the address lies below the base.
  assign off      = {1'b0, addr_i} - {1'b0, BASE_ADDR};
  assign in_range = !off[32] && (off < SPAN);
  assign bad_size = (size_i == 3'b011) || (size_i[2:1] == 2'b11);
  assign is_half  = (size_i[1:0] == 2'b01);
  assign is_word  = (size_i == 3'b010);
  assign fault    = !in_range || bad_size || (is_half && addr_i[0]) ||
                    (is_word && (addr_i[1:0] != 2'b00));
  assign idx      = addr_i[AW+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hold      = 1'b0;
    do_access = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            do_access = 1'b1;
          end else begin
            state_n = WAIT;
            cnt_n   = 4'(WAIT_CYCLES - 1);
            hold    = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
          hold  = 1'b1;
        end else begin
          do_access = req;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Gating with rst_n drops hold at once and blocks any write while reset is held.
  assign hold_o = hold && rst_n;

  always_comb begin
    be    = 4'b1111;
    wlane = wdata_i;
    if (size_i[1:0] == 2'b00) begin
      be    = 4'b0001 << addr_i[1:0];
      wlane = {4{wdata_i[7:0]}};
    end else if (size_i[1:0] == 2'b01) begin
      be    = addr_i[1] ? 4'b1100 : 4'b0011;
      wlane = {2{wdata_i[15:0]}};
    end
  end

  always_ff @(posedge clk) begin
    if (do_access && rst_n && we_i && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  assign rword = mem[idx];
  assign lane  = rword >> {addr_i[1:0], 3'b000};
  assign half  = addr_i[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    case (size_i)
      3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_val = {{16{half[15]}}, half};
      3'b100:  load_val = {24'd0, lane[7:0]};
      3'b101:  load_val = {16'd0, half};
      default: load_val = rword;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_o <= 32'd0;
      err_o   <= 1'b0;
    end else begin
      err_o <= do_access && fault;
      if (do_access) begin
        if (fault)                rdata_o <= 32'd0;
        else if (re_i && !we_i)   rdata_o <= load_val;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a zero-wait and a three-wait instance checked against
// directed tables, hand sequences and a byte-array reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_responder;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0_n, we0, re0, hold0, err0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [2:0]  size0;
  logic        rst3_n, we3, re3, hold3, err3;
  logic [31:0] addr3, wdata3, rdata3;
  logic [2:0]  size3;

  dmem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst0_n), .addr_i(addr0), .wdata_i(wdata0), .we_i(we0),
    .re_i(re0), .size_i(size0), .rdata_o(rdata0), .hold_o(hold0), .err_o(err0));

  dmem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .addr_i(addr3), .wdata_i(wdata3), .we_i(we3),
    .re_i(re3), .size_i(size3), .rdata_o(rdata3), .hold_o(hold3), .err_o(err3));

  logic [7:0]  m0 [0:4*DEPTH-1];
  logic [7:0]  m3 [0:4*DEPTH-1];
  logic [31:0] rd0_exp, rd3_exp;
  int          nvec = 0;
  int          nerr = 0;

  typedef struct {
    logic        we, re;
    logic [31:0] a, w;
    logic [2:0]  s;
    logic [31:0] rd;
    logic        er;
    string       nm;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Byte-addressed memory model; rd holds the expected rdata and is updated in place.
  function automatic void model(input bit w3, input logic we, input logic re,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [2:0] s, inout logic [31:0] rd,
                                output logic er);
    longint off = longint'(a) - longint'(BASE);
    int nb = 1;
    bit sgn = 0, bad = 0;
    longint v = 0;
    er = 1'b0;
    case (s)
      3'd0: begin nb = 1; sgn = 1; end
      3'd1: begin nb = 2; sgn = 1; end
      3'd2: nb = 4;
      3'd4: nb = 1;
      3'd5: nb = 2;
      default: bad = 1;
    endcase
    if (!(we || re)) return;
    if (bad || off < 0 || off >= 4*DEPTH || (a % nb) != 0) begin
      er = 1'b1;
      rd = 32'd0;
      return;
    end
    if (we) begin
      for (int i = 0; i < nb; i++) begin
        if (w3) m3[int'(off) + i] = wd[8*i +: 8];
        else    m0[int'(off) + i] = wd[8*i +: 8];
      end
    end else begin
      for (int i = 0; i < nb; i++)
        v += longint'(w3 ? m3[int'(off) + i] : m0[int'(off) + i]) << (8*i);
      if (sgn && ((v >> (8*nb - 1)) & 1) == 1) v -= (longint'(1) << (8*nb));
      rd = v[31:0];
    end
  endfunction

  task automatic op0(input logic we, input logic re, input logic [31:0] a,
                     input logic [31:0] w, input logic [2:0] s,
                     input logic [31:0] exp_rd, input logic exp_er, input string nm);
    we0 = we; re0 = re; addr0 = a; wdata0 = w; size0 = s;
    #1 chk({nm, " hold"}, 32'(hold0), 32'd0);
    @(posedge clk); #1;
    chk({nm, " rdata"}, rdata0, exp_rd);
    chk({nm, " err"}, 32'(err0), 32'(exp_er));
  endtask

  task automatic op3(input logic we, input logic re, input logic [31:0] a,
                     input logic [31:0] w, input logic [2:0] s,
                     input logic [31:0] exp_rd, input logic exp_er, input string nm);
    we3 = we; re3 = re; addr3 = a; wdata3 = w; size3 = s;
    if (we || re) begin
      for (int c = 0; c < 3; c++) begin
        #1 chk($sformatf("%s hold T+%0d", nm, c), 32'(hold3), 32'd1);
        if (c == 1) chk({nm, " err during hold"}, 32'(err3), 32'd0);
        @(posedge clk); #1;
      end
      chk({nm, " hold T+3"}, 32'(hold3), 32'd0);
    end else begin
      #1 chk({nm, " hold idle"}, 32'(hold3), 32'd0);
    end
    @(posedge clk); #1;
    chk({nm, " rdata"}, rdata3, exp_rd);
    chk({nm, " err"}, 32'(err3), 32'(exp_er));
  endtask

  task automatic rand_req(output logic we, output logic re, output logic [31:0] a,
                          output logic [31:0] w, output logic [2:0] s);
    int k = $urandom_range(0, 3);
    logic [2:0] legal [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    we = (k >= 2);
    re = (k == 1) || (k == 3);
    w  = $urandom;
    s  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : legal[$urandom_range(0, 4)];
    case ($urandom_range(0, 15))
      0: a = BASE - 32'd4;
      1: a = BASE + 32'(4*DEPTH);
      default: a = BASE + 32'($urandom_range(0, 63));
    endcase
  endtask

  initial begin
    logic        we, re, er;
    logic [31:0] a, w;
    logic [2:0]  s;

    rst0_n = 0; rst3_n = 0;
    {we0, re0, addr0, wdata0, size0} = '0;
    {we3, re3, addr3, wdata3, size3} = '0;
    rd0_exp = 0; rd3_exp = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset rdata0", rdata0, 0);  chk("reset hold0", 32'(hold0), 0);  chk("reset err0", 32'(err0), 0);
    chk("reset rdata3", rdata3, 0);  chk("reset hold3", 32'(hold3), 0);  chk("reset err3", 32'(err3), 0);
    rst0_n = 1; rst3_n = 1;
    @(posedge clk); #1;

    tbl.push_back('{1, 0, 32'h1000_0000, 32'h0BAD_F00D, 3'b010, 32'h0000_0000, 0, "sw word0"});
    tbl.push_back('{1, 0, 32'h1000_0010, 32'hDEAD_BEEF, 3'b010, 32'h0000_0000, 0, "sw 0x10"});
    tbl.push_back('{0, 1, 32'h1000_0010, 32'h0,         3'b010, 32'hDEAD_BEEF, 0, "lw 0x10"});
    tbl.push_back('{1, 0, 32'h1000_0020, 32'h1122_8344, 3'b010, 32'hDEAD_BEEF, 0, "sw 0x20"});
    tbl.push_back('{1, 0, 32'h1000_0021, 32'h0000_00A5, 3'b000, 32'hDEAD_BEEF, 0, "sb 0x21"});
    tbl.push_back('{0, 1, 32'h1000_0020, 32'h0,         3'b010, 32'h1122_A544, 0, "lw 0x20"});
    tbl.push_back('{0, 1, 32'h1000_0021, 32'h0,         3'b000, 32'hFFFF_FFA5, 0, "lb 0x21"});
    tbl.push_back('{0, 1, 32'h1000_0021, 32'h0,         3'b100, 32'h0000_00A5, 0, "lbu 0x21"});
    tbl.push_back('{0, 1, 32'h1000_0022, 32'h0,         3'b001, 32'h0000_1122, 0, "lh 0x22"});
    tbl.push_back('{1, 0, 32'h1000_0022, 32'h0000_8001, 3'b001, 32'h0000_1122, 0, "sh 0x22"});
    tbl.push_back('{0, 1, 32'h1000_0022, 32'h0,         3'b001, 32'hFFFF_8001, 0, "lh 0x22 new"});
    tbl.push_back('{0, 1, 32'h1000_0012, 32'h0,         3'b101, 32'h0000_DEAD, 0, "lhu 0x12"});
    tbl.push_back('{0, 1, 32'h1000_0002, 32'h0,         3'b010, 32'h0000_0000, 1, "lw misaligned"});
    tbl.push_back('{1, 0, 32'h0FFF_FFFC, 32'h0000_0001, 3'b010, 32'h0000_0000, 1, "sw below base"});
    tbl.push_back('{0, 1, 32'h1000_0000, 32'h0,         3'b010, 32'h0BAD_F00D, 0, "lw word0"});
    tbl.push_back('{0, 1, 32'h1000_0010, 32'h0,         3'b011, 32'h0000_0000, 1, "size 011"});
    tbl.push_back('{0, 1, 32'h1000_0011, 32'h0,         3'b001, 32'h0000_0000, 1, "lh odd"});
    tbl.push_back('{1, 1, 32'h1000_0040, 32'h0000_0005, 3'b010, 32'h0000_0000, 0, "we+re 0x40"});
    tbl.push_back('{0, 1, 32'h1000_0040, 32'h0,         3'b010, 32'h0000_0005, 0, "lw 0x40"});
    tbl.push_back('{1, 0, 32'h1000_03FC, 32'hCAFE_F00D, 3'b010, 32'h0000_0005, 0, "sw top word"});
    tbl.push_back('{0, 1, 32'h1000_03FC, 32'h0,         3'b010, 32'hCAFE_F00D, 0, "lw top word"});
    tbl.push_back('{0, 1, 32'h1000_0400, 32'h0,         3'b010, 32'h0000_0000, 1, "lw past end"});
    tbl.push_back('{0, 0, 32'h1000_0040, 32'h0,         3'b010, 32'h0000_0000, 0, "no request"});

    foreach (tbl[i]) begin
      model(0, tbl[i].we, tbl[i].re, tbl[i].a, tbl[i].w, tbl[i].s, rd0_exp, er);
      op0(tbl[i].we, tbl[i].re, tbl[i].a, tbl[i].w, tbl[i].s, tbl[i].rd, tbl[i].er, tbl[i].nm);
      rd0_exp = tbl[i].rd;
    end

    // Fill the random window so every in-range load has defined data.
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      model(0, 1, 0, BASE + 32'(4*i), w, 3'b010, rd0_exp, er);
      op0(1, 0, BASE + 32'(4*i), w, 3'b010, rd0_exp, er, "fill0");
    end
    for (int n = 0; n < 400; n++) begin
      rand_req(we, re, a, w, s);
      model(0, we, re, a, w, s, rd0_exp, er);
      op0(we, re, a, w, s, rd0_exp, er, $sformatf("rand0 #%0d", n));
    end
    {we0, re0} = 2'b00;

    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      model(1, 1, 0, BASE + 32'(4*i), w, 3'b010, rd3_exp, er);
      op3(1, 0, BASE + 32'(4*i), w, 3'b010, rd3_exp, er, "fill3");
    end
    model(1, 0, 1, 32'h1000_0010, 0, 3'b010, rd3_exp, er);
    op3(0, 1, 32'h1000_0010, 0, 3'b010, rd3_exp, er, "wait lw 0x10");
    model(1, 0, 1, 32'h1000_0002, 0, 3'b010, rd3_exp, er);
    op3(0, 1, 32'h1000_0002, 0, 3'b010, 32'h0, 1'b1, "wait lw misaligned");
    for (int n = 0; n < 60; n++) begin
      rand_req(we, re, a, w, s);
      model(1, we, re, a, w, s, rd3_exp, er);
      op3(we, re, a, w, s, rd3_exp, er, $sformatf("rand3 #%0d", n));
    end

    // Reset in the second held cycle of a store: nothing may be written.
    we3 = 1; re3 = 0; addr3 = 32'h1000_0008; wdata3 = 32'h1234_5678; size3 = 3'b010;
    #1 chk("rstwait hold T", 32'(hold3), 1);
    @(posedge clk); #1;
    rst3_n = 0;
    #1 chk("rstwait hold async", 32'(hold3), 0);
    chk("rstwait rdata", rdata3, 0);
    @(posedge clk); @(posedge clk); #1;
    we3 = 0; rst3_n = 1; rd3_exp = 0;
    @(posedge clk); #1;
    model(1, 0, 1, 32'h1000_0008, 0, 3'b010, rd3_exp, er);
    op3(0, 1, 32'h1000_0008, 0, 3'b010, rd3_exp, er, "rstwait old value");
    {we3, re3} = 2'b00;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
